// File: rtl/phase_transmitter.sv
// -----------------------------------------------------------------------------
// phase_transmitter
//
// FPGA->host half of the proto245 link. On a one-cycle send_req the live
// phase table is snapshotted and a readback frame is streamed into the TX FIFO:
//
//   HEADER, CNT_HI, CNT_LO, phase[0..N-1], CHECKSUM
//
// The checksum is the XOR of the N phase bytes only. The host uses the frame
// to confirm that a phase table it wrote has been applied.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous, active-high reset
//   phases       in   live phase table, PHASE_W bits x NUM_CHANNELS
//   send_req     in   one-cycle request to emit one frame (honoured in IDLE only)
//   busy         out  frame in progress
//   done         out  one-cycle pulse after the last byte is accepted
//   txfifo_load  in   FIFO occupancy (informational, not used)
//   txfifo_full  in   FIFO cannot accept a byte this cycle
//   txfifo_wr    out  txfifo_data is written on this rising edge
//   txfifo_data  out  outgoing byte (registered, held until transferred)
// -----------------------------------------------------------------------------
module phase_transmitter #(
    parameter int unsigned CLK_FREQ       = 256,
    parameter int unsigned OUT_FREQ       = 1,
    parameter int unsigned NUM_CHANNELS   = 256,
    parameter int unsigned TX_FIFO_LOAD_W = 13,
    parameter logic [7:0]  RESP_HEADER    = 8'h81,
    localparam int unsigned PHASE_W       = $clog2(CLK_FREQ / OUT_FREQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PHASE_W-1:0]        phases [NUM_CHANNELS],
    input  logic                      send_req,
    output logic                      busy,
    output logic                      done,
    input  logic [TX_FIFO_LOAD_W-1:0] txfifo_load,
    input  logic                      txfifo_full,
    output logic                      txfifo_wr,
    output logic [7:0]                txfifo_data
);

    localparam int unsigned IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);
    localparam logic [15:0] CNT_WORD = 16'(NUM_CHANNELS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_CNT_HI,
        S_CNT_LO,
        S_PHASE,
        S_CSUM
    } state_t;

    state_t             state, state_d;
    logic [PHASE_W-1:0] snapshot [NUM_CHANNELS];
    logic               snap_load;
    logic [IDX_W-1:0]   index, index_d;
    logic [7:0]         csum, csum_d;
    logic [7:0]         data_q, data_d;
    logic               done_q, done_d;
    logic               xfer;

    // Occupancy is informational only; fold it into a deliberately unused net.
    logic unused_load;
    assign unused_load = ^txfifo_load;

    // A byte moves on every edge where the FIFO is not full and a frame is open.
    assign xfer        = (state != S_IDLE) && !txfifo_full;
    assign txfifo_wr   = xfer;
    assign txfifo_data = data_q;
    assign busy        = (state != S_IDLE);
    assign done        = done_q;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            index  <= '0;
            csum   <= '0;
            data_q <= '0;
            done_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                snapshot[i] <= '0;
            end
        end else begin
            state  <= state_d;
            index  <= index_d;
            csum   <= csum_d;
            data_q <= data_d;
            done_q <= done_d;
            if (snap_load) begin
                for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                    snapshot[i] <= phases[i];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-byte logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state;
        index_d   = index;
        csum_d    = csum;
        data_d    = data_q;
        done_d    = 1'b0;
        snap_load = 1'b0;

        case (state)
            S_IDLE: begin
                if (send_req) begin
                    snap_load = 1'b1;
                    csum_d    = '0;
                    index_d   = '0;
                    data_d    = RESP_HEADER;
                    state_d   = S_HDR;
                end
            end
            S_HDR: begin
                if (xfer) begin
                    data_d  = CNT_WORD[15:8];
                    state_d = S_CNT_HI;
                end
            end
            S_CNT_HI: begin
                if (xfer) begin
                    data_d  = CNT_WORD[7:0];
                    state_d = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (xfer) begin
                    data_d  = 8'(snapshot[0]);
                    state_d = S_PHASE;
                end
            end
            S_PHASE: begin
                if (xfer) begin
                    // The byte leaving now is folded in; on the last phase the
                    // folded value itself becomes the checksum byte.
                    csum_d = csum ^ data_q;
                    if (index == LAST_IDX) begin
                        data_d  = csum ^ data_q;
                        state_d = S_CSUM;
                    end else begin
                        index_d = index + 1'b1;
                        data_d  = 8'(snapshot[index + 1'b1]);
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_phase_transmitter.sv
module tb_phase_transmitter;

    localparam int unsigned N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  phases [N];
    logic        send_req = 1'b0;
    logic        busy;
    logic        done;
    logic [12:0] txfifo_load = '0;
    logic        txfifo_full = 1'b0;
    logic        txfifo_wr;
    logic [7:0]  txfifo_data;

    int n_cmp = 0;
    int n_err = 0;

    // Monitor state (sampled on the falling edge, away from the active edge)
    int          cyc = 0;
    int          n_done = 0;
    int          n_busy = 0;
    logic [7:0]  got[$];
    int          wcyc[$];
    logic [7:0]  exp_q[$];

    phase_transmitter #(
        .CLK_FREQ      (256),
        .OUT_FREQ      (1),
        .NUM_CHANNELS  (N),
        .TX_FIFO_LOAD_W(13),
        .RESP_HEADER   (8'h81)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .phases     (phases),
        .send_req   (send_req),
        .busy       (busy),
        .done       (done),
        .txfifo_load(txfifo_load),
        .txfifo_full(txfifo_full),
        .txfifo_wr  (txfifo_wr),
        .txfifo_data(txfifo_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (txfifo_wr === 1'b1) begin
            got.push_back(txfifo_data);
            wcyc.push_back(cyc);
        end
        if (done === 1'b1) n_done++;
        if (busy === 1'b1) n_busy++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got.delete();
        wcyc.delete();
        exp_q.delete();
        n_done = 0;
        n_busy = 0;
    endtask

    task automatic set_phases(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
        phases[0] = a; phases[1] = b; phases[2] = c; phases[3] = d;
    endtask

    // Reference frame for N=4: header, count, phases, XOR of phases
    task automatic push_frame(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h04);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
        exp_q.push_back(a ^ b ^ c ^ d);
    endtask

    task automatic send();
        send_req = 1'b1;
        tick();
        send_req = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input bit rnd_full);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            if (rnd_full) txfifo_full = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        txfifo_full = 1'b0;
        check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    endtask

    task automatic compare_stream(input string tag);
        int n;
        check({tag, "_len"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_byte%0d", tag, i), {24'd0, got[i]}, {24'd0, exp_q[i]});
        end
    endtask

    initial begin
        set_phases(8'h01, 8'h12, 8'h34, 8'h56);

        // Reset state
        #2;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_wr",   {31'd0, txfifo_wr}, 32'd0);
        check("rst_data", {24'd0, txfifo_data}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // 1: single frame, FIFO never full
        clear_mon();
        push_frame(8'h01, 8'h12, 8'h34, 8'h56);
        send();
        check("t1_busy_after_req", {31'd0, busy}, 32'd1);
        wait_done("t1", 30, 1'b0);
        check("t1_busy_in_done", {31'd0, busy}, 32'd0);
        tick(); tick();
        compare_stream("t1");
        check("t1_done_count", n_done, 1);
        check("t1_busy_cycles", n_busy, 8);
        if (wcyc.size() == 8) check("t1_consecutive", wcyc[7] - wcyc[0], 7);
        else check("t1_write_count", wcyc.size(), 8);

        // 2: back-pressure while 0x12 is pending
        clear_mon();
        push_frame(8'h01, 8'h12, 8'h34, 8'h56);
        send();
        repeat (4) tick();
        txfifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t2_wr_stall%0d", i), {31'd0, txfifo_wr}, 32'd0);
            check($sformatf("t2_data_stall%0d", i), {24'd0, txfifo_data}, 32'h12);
            tick();
        end
        txfifo_full = 1'b0;
        wait_done("t2", 30, 1'b0);
        tick();
        compare_stream("t2");

        // 3: phases change after the snapshot
        clear_mon();
        push_frame(8'h01, 8'h12, 8'h34, 8'h56);
        send();
        set_phases(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        wait_done("t3", 30, 1'b0);
        tick();
        compare_stream("t3");
        set_phases(8'h01, 8'h12, 8'h34, 8'h56);

        // 4: mid-frame request ignored; request in done cycle accepted
        clear_mon();
        push_frame(8'h01, 8'h12, 8'h34, 8'h56);
        push_frame(8'h01, 8'h12, 8'h34, 8'h56);
        send();
        tick(); tick();
        send();
        wait_done("t4a", 30, 1'b0);
        send();
        wait_done("t4b", 30, 1'b0);
        tick(); tick();
        compare_stream("t4");
        check("t4_done_count", n_done, 2);
        if (wcyc.size() == 16) check("t4_restart_gap", wcyc[8] - wcyc[7], 2);
        else check("t4_write_count", wcyc.size(), 16);

        // 5: reset after the first phase byte
        clear_mon();
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h01);
        send();
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check("t5_wr_on_rst", {31'd0, txfifo_wr}, 32'd0);
        check("t5_busy_on_rst", {31'd0, busy}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        compare_stream("t5");
        check("t5_no_done", n_done, 0);
        clear_mon();
        push_frame(8'h01, 8'h12, 8'h34, 8'h56);
        send();
        wait_done("t5r", 30, 1'b0);
        tick();
        compare_stream("t5r");

        // 6: random back-pressure over 20 frames with random tables
        clear_mon();
        for (int f = 0; f < 20; f++) begin
            logic [7:0] a, b, c, d;
            a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
            set_phases(a, b, c, d);
            push_frame(a, b, c, d);
            send();
            set_phases(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            wait_done($sformatf("t6f%0d", f), 300, 1'b1);
        end
        tick();
        compare_stream("t6");
        check("t6_done_count", n_done, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
